// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Optional packet lock (whole packets per requester) enabled by defining UART_ARB_LOCK_EN.

// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for !tx_busy and an eligible request; grants here
// START     | tx_start high for this single cycle
// WAIT_BUSY | waiting for the transmitter to raise tx_busy
// WAIT_DONE | waiting for tx_busy to fall; then active drops

module uart_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     active
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    next_ptr;
  logic             win_found;
  logic             accept;
  logic [N_REQ-1:0] eligible;
  logic [7:0]       win_byte;

`ifdef UART_ARB_LOCK_EN
  logic          locked;
  logic [IW-1:0] lock_id;

  // While a packet is open only its owner may be granted.
  always_comb begin
    eligible = req_valid;
    if (locked) begin
      for (int i = 0; i < N_REQ; i++) begin
        eligible[i] = req_valid[i] && (IW'(i) == lock_id);
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  // Circular search starting at ptr: first eligible index wins.
  always_comb begin
    int idx_i;
    idx_i     = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_i = int'(ptr) + k;
      if (idx_i >= N_REQ) begin
        idx_i = idx_i - N_REQ;
      end
      if (!win_found && eligible[IW'(idx_i)]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx_i);
      end
    end
  end

  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == win_idx) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  assign next_ptr = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + IW'(1);
  assign accept   = (state == IDLE) && !tx_busy && win_found;

  always_comb begin
    req_ready = '0;
    if (!rst && accept) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      active   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      locked   <= 1'b0;
      lock_id  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= win_byte;
            grant_id <= win_idx;
            active   <= 1'b1;
            tx_start <= 1'b1;
            state    <= START;
`ifdef UART_ARB_LOCK_EN
            if (req_last[win_idx]) begin
              locked <= 1'b0;
              ptr    <= next_ptr;
            end else begin
              locked  <= 1'b1;
              lock_id <= win_idx;
            end
`else
            ptr <= next_ptr;
`endif
          end
        end
        START: begin
          tx_start <= 1'b0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 10-cycle busy transmitter model.
// Lock-mode sequences are compiled in when UART_ARB_LOCK_EN is defined.

module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int busy_cnt = 0;
  logic busy_force;
  int starts_in_busy = 0;
  int ready_cnt [4] = '{0, 0, 0, 0};
  int grant_q [$];
  int data_q  [$];
  int scyc_q  [$];

  uart_tx_arbiter #(.N_REQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for 10 cycles after each start pulse.
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_force | (busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      grant_q.push_back(int'(grant_id));
      data_q.push_back(int'(tx_data));
      scyc_q.push_back(cyc);
      if (tx_busy) starts_in_busy++;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) ready_cnt[i]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input logic [3:0] exp);
    int n = 0;
    while (req_ready == 4'b0000 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(active), 32'd0);
  endtask

  initial begin
    int c0;
    int base;
    int base_sib;
    int nready;
    int n;
    int order [5] = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    busy_force = 1'b0;
    req_valid = 4'b0000;
    req_data = 32'h0;
    req_last = 4'b0000;
    tick();
    tick();

    // Single requester, checked through reset release.
    req_valid = 4'b0100;
    req_data[23:16] = 8'hA5;
    #1;
    check("ready_in_reset", 32'(req_ready), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    rst = 1'b0;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    c0 = cyc;
    req_valid = 4'b0000;
    check("single_start", 32'(tx_start), 32'h1);
    check("single_data", 32'(tx_data), 32'hA5);
    check("single_grant", 32'(grant_id), 32'h2);
    check("single_active", 32'(active), 32'h1);
    check("single_ready_drop", 32'(req_ready), 32'h0);
    tick();
    check("single_start_pulse", 32'(tx_start), 32'h0);
    wait_idle("single_idle");
    check("single_active_cycles", 32'(cyc - c0), 32'd12);
    check("single_ready_cnt", 32'(ready_cnt[2]), 32'd1);
    check("single_start_cnt", 32'(grant_q.size()), 32'd1);

    // All four continuously valid after reset: order 0,1,2,3,0.
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    tick();
    rst = 1'b0;
    base = grant_q.size();
    base_sib = starts_in_busy;
    n = 0;
    while (grant_q.size() < base + 5 && n < 300) begin
      tick();
      n++;
    end
    req_valid = 4'b0000;
    check("rr_count", 32'(grant_q.size() - base), 32'd5);
    if (grant_q.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("rr_grant%0d", i), 32'(grant_q[base+i]), 32'(order[i]));
        check($sformatf("rr_data%0d", i), 32'(data_q[base+i]), 32'(16 + order[i]));
      end
      check("rr_spacing", 32'(scyc_q[base+1] - scyc_q[base]), 32'd13);
    end
    check("rr_start_in_busy", 32'(starts_in_busy - base_sib), 32'd0);
    wait_idle("rr_idle");

    // Busy already high when a request appears.
    busy_force = 1'b1;
    req_valid = 4'b0001;
    nready = 0;
    repeat (6) begin
      tick();
      if (req_ready != 4'b0000) nready++;
    end
    check("busy_no_ready", 32'(nready), 32'd0);
    busy_force = 1'b0;
    #1;
    check("busy_release_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("busy_grant", 32'(grant_id), 32'h0);
    check("busy_start", 32'(tx_start), 32'h1);

    // Reset mid-byte while the transmitter is still busy (ptr was 1).
    repeat (4) tick();
    check("mid_busy", 32'(tx_busy), 32'h1);
    check("mid_active", 32'(active), 32'h1);
    rst = 1'b1;
    req_valid = 4'b1001;
    tick();
    rst = 1'b0;
    base = grant_q.size();
    check("mid_rst_start", 32'(tx_start), 32'h0);
    check("mid_rst_data", 32'(tx_data), 32'h0);
    check("mid_rst_grant", 32'(grant_id), 32'h0);
    check("mid_rst_active", 32'(active), 32'h0);
    #1;
    check("mid_ready_busy", 32'(req_ready), 32'h0);
    n = 0;
    while (tx_busy && n < 50) begin
      tick();
      n++;
    end
    check("mid_no_start", 32'(grant_q.size() - base), 32'd0);
    check("mid_ready_ptr0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("mid_grant", 32'(grant_id), 32'h0);
    check("mid_data", 32'(tx_data), 32'h10);
    check("mid_start", 32'(tx_start), 32'h1);
    wait_idle("mid_idle");

`ifdef UART_ARB_LOCK_EN
    // Packet lock: requester 1 sends three bytes while requester 0 waits.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = grant_q.size();
    req_valid = 4'b0010;
    req_data[15:8] = 8'h31;
    req_last = 4'b0000;
    wait_ready("lock_b1", 4'b0010);
    tick();
    req_valid = 4'b0011;
    req_data[15:8] = 8'h32;
    req_data[7:0] = 8'h05;
    wait_ready("lock_b2", 4'b0010);
    tick();
    req_data[15:8] = 8'h33;
    req_last = 4'b0010;
    wait_ready("lock_b3", 4'b0010);
    tick();
    req_valid = 4'b0001;
    req_last = 4'b0000;
    wait_ready("lock_r0", 4'b0001);
    tick();
    req_valid = 4'b0000;
    check("lock_count", 32'(grant_q.size() - base), 32'd4);
    if (grant_q.size() >= base + 4) begin
      check("lock_g0", 32'(grant_q[base]), 32'd1);
      check("lock_g1", 32'(grant_q[base+1]), 32'd1);
      check("lock_g2", 32'(grant_q[base+2]), 32'd1);
      check("lock_g3", 32'(grant_q[base+3]), 32'd0);
      check("lock_d2", 32'(data_q[base+2]), 32'h33);
    end
    wait_idle("lock_idle");

    // Lock stall: requester 1 drops valid mid-packet while 3 is valid.
    req_valid = 4'b0010;
    req_data[15:8] = 8'h41;
    req_last = 4'b0000;
    wait_ready("stall_b1", 4'b0010);
    tick();
    req_valid = 4'b1000;
    req_data[31:24] = 8'h77;
    nready = 0;
    repeat (33) begin
      tick();
      if (req_ready != 4'b0000) nready++;
    end
    check("stall_no_grant", 32'(nready), 32'd0);
    req_valid = 4'b1010;
    req_data[15:8] = 8'h42;
    req_last = 4'b0010;
    wait_ready("stall_resume", 4'b0010);
    tick();
    check("stall_resume_data", 32'(tx_data), 32'h42);
    req_valid = 4'b1000;
    req_last = 4'b0000;
    wait_ready("stall_then_r3", 4'b1000);
    tick();
    req_valid = 4'b0000;
    check("stall_r3_data", 32'(tx_data), 32'h77);
    wait_idle("stall_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
